// File: rtl/hub75_bcm_scheduler.sv
// hub75_bcm_scheduler: HUB75 BCM scan sequencer (fetch, shift, latch, weighted unblank per row/plane).
module hub75_bcm_scheduler #(
    parameter int ROWBITS = 5,
    parameter int COLS = 64,
    parameter int PLANES = 8,
    parameter int BASE_ON = 4,
    localparam int COLBITS = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int PLANEBITS = (PLANES > 1) ? $clog2(PLANES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic                 fb_rd_en,
    output logic [ROWBITS-1:0]   fb_rd_row,
    output logic [COLBITS-1:0]   fb_rd_col,
    output logic [PLANEBITS-1:0] fb_rd_plane,
    input  logic [2:0]           fb_rgb1,
    input  logic [2:0]           fb_rgb2,
    output logic [2:0]           led_rgb1,
    output logic [2:0]           led_rgb2,
    output logic                 led_sclk,
    output logic                 led_latch,
    output logic                 led_blank,
    output logic [ROWBITS-1:0]   led_addr,
    output logic                 frame_done
);
    localparam int ONBITS = $clog2(BASE_ON) + PLANES;

    typedef enum logic [2:0] {IDLE, PRE, SHIFT_L, SHIFT_H, BLANK, LATCH, SHOW} state_t;

    state_t                 state, nxt;
    logic [COLBITS-1:0]     pix, pix_nxt;
    logic [ONBITS-1:0]      on_cnt;
    logic [ROWBITS-1:0]     row;
    logic [PLANEBITS-1:0]   plane;
    logic                   rd_q;
    logic                   show_end;

    assign fb_rd_row = row;
    assign fb_rd_plane = plane;

    always_comb begin
        nxt = state;
        show_end = state == SHOW && on_cnt == ONBITS'(1);
        pix_nxt = state == PRE ? '0 : pix + 1'b1;
        case (state)
            IDLE:    nxt = enable ? PRE : IDLE;
            PRE:     nxt = SHIFT_L;
            SHIFT_L: nxt = SHIFT_H;
            SHIFT_H: nxt = pix == COLBITS'(COLS - 1) ? BLANK : SHIFT_L;
            BLANK:   nxt = LATCH;
            LATCH:   nxt = SHOW;
            SHOW:    nxt = !show_end ? SHOW : enable ? PRE : IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pix <= '0;
            on_cnt <= '0;
            row <= '0;
            plane <= '0;
            rd_q <= 1'b0;
            fb_rd_en <= 1'b0;
            fb_rd_col <= '0;
            led_rgb1 <= '0;
            led_rgb2 <= '0;
            led_sclk <= 1'b0;
            led_latch <= 1'b0;
            led_blank <= 1'b1;
            led_addr <= '0;
            frame_done <= 1'b0;
        end else begin
            state <= nxt;
            rd_q <= fb_rd_en;
            led_sclk <= nxt == SHIFT_H;
            led_latch <= nxt == LATCH;
            led_blank <= nxt != SHOW;
            frame_done <= show_end && plane == PLANEBITS'(PLANES - 1) && row == '1;
            // Framebuffer data is valid the cycle after each read strobe.
            if (rd_q) begin
                led_rgb1 <= fb_rgb1;
                led_rgb2 <= fb_rgb2;
            end
            if (nxt == PRE) begin
                fb_rd_en <= 1'b1;
                fb_rd_col <= '0;
            end else if (nxt == SHIFT_L) begin
                fb_rd_en <= pix_nxt < COLBITS'(COLS - 1);
                fb_rd_col <= pix_nxt + 1'b1;
                pix <= pix_nxt;
            end else begin
                fb_rd_en <= 1'b0;
            end
            if (nxt == LATCH)
                led_addr <= row;
            if (nxt == SHOW && state != SHOW)
                on_cnt <= ONBITS'(BASE_ON) << plane;
            else if (state == SHOW)
                on_cnt <= on_cnt - 1'b1;
            if (show_end) begin
                plane <= plane == PLANEBITS'(PLANES - 1) ? '0 : plane + 1'b1;
                row <= plane == PLANEBITS'(PLANES - 1) ? row + 1'b1 : row;
            end
        end
    end
endmodule
